// File: rtl/gpio_cfg_pkg.sv
// Shared constants for the per-pad GPIO configuration register.
// Field indices locate each pad control inside the committed configuration word.
package gpio_cfg_pkg;

    localparam int GPIO_CFG_WIDTH = 10;

    localparam int CFG_MGMT_ENA      = 0;
    localparam int CFG_OUTENB        = 1;
    localparam int CFG_HOLDOVER      = 2;
    localparam int CFG_INP_DIS       = 3;
    localparam int CFG_PULLUP        = 4;
    localparam int CFG_PULLDOWN      = 5;
    localparam int CFG_SCHMITT_SEL   = 6;
    localparam int CFG_SLEW_SEL      = 7;
    localparam int CFG_DRIVE_SEL_LSB = 8;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/gpio_config_shreg_if.sv
// Serial configuration chain bus for one pad.
// The pad register is the slave; housekeeping or the previous pad is the master.
interface gpio_config_shreg_if #(
    parameter int WIDTH = gpio_cfg_pkg::GPIO_CFG_WIDTH
);
    logic [WIDTH-1:0] gpio_defaults;
    logic             serial_data_in;
    logic             serial_shift;
    logic             serial_load;
    logic             defaults_reload;
    logic             serial_data_out;
    logic [WIDTH-1:0] gpio_config;
    logic             mgmt_ena;
    logic             gpio_outenb;
    logic             cfg_valid;
    logic             cfg_short;

    modport slave (
        input  gpio_defaults, serial_data_in, serial_shift, serial_load, defaults_reload,
        output serial_data_out, gpio_config, mgmt_ena, gpio_outenb, cfg_valid, cfg_short
    );

    modport master (
        output gpio_defaults, serial_data_in, serial_shift, serial_load, defaults_reload,
        input  serial_data_out, gpio_config, mgmt_ena, gpio_outenb, cfg_valid, cfg_short
    );
endinterface

// File: rtl/gpio_config_shreg.sv
// Purpose: per-pad config register, captures tie-cell defaults then accepts serial shift/load.
// Latency: config valid 1 clock after reset release; load/reload commit on the next edge.
// Backpressure: none, every shift/load/reload strobe is consumed on the cycle it is seen.
module gpio_config_shreg
    import gpio_cfg_pkg::*;
#(
    parameter int WIDTH = GPIO_CFG_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                    serial_clock,
    input  logic                    resetn,
    gpio_config_shreg_if.slave      cfg_bus
);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   shreg, shreg_nxt;
    logic [WIDTH-1:0]   cfg, cfg_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               vld, vld_nxt;
    logic               short, short_nxt;

    always_ff @(posedge serial_clock or negedge resetn) begin
        if (!resetn) begin
            state <= INIT;
            shreg <= '0;
            cfg   <= '0;
            cnt   <= '0;
            vld   <= 1'b0;
            short <= 1'b0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cfg   <= cfg_nxt;
            cnt   <= cnt_nxt;
            vld   <= vld_nxt;
            short <= short_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cfg_nxt   = cfg;
        cnt_nxt   = cnt;
        vld_nxt   = vld;
        short_nxt = short;
        unique case (state)
            INIT: begin
                shreg_nxt = cfg_bus.gpio_defaults;
                cfg_nxt   = cfg_bus.gpio_defaults;
                cnt_nxt   = '0;
                vld_nxt   = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                if (cfg_bus.defaults_reload) begin
                    shreg_nxt = cfg_bus.gpio_defaults;
                    cfg_nxt   = cfg_bus.gpio_defaults;
                    cnt_nxt   = '0;
                    short_nxt = 1'b0;
                end else begin
                    // A load commits the pre-shift contents; a coincident shift counts as bit one.
                    if (cfg_bus.serial_load) begin
                        cfg_nxt   = shreg;
                        cnt_nxt   = '0;
                        short_nxt = short | (cnt < CNT_W'(WIDTH));
                    end
                    if (cfg_bus.serial_shift) begin
                        shreg_nxt = {shreg[WIDTH-2:0], cfg_bus.serial_data_in};
                        if (cfg_bus.serial_load)
                            cnt_nxt = CNT_W'(1);
                        else if (cnt != CNT_W'(WIDTH))
                            cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    assign cfg_bus.serial_data_out = shreg[WIDTH-1];
    assign cfg_bus.gpio_config     = cfg;
    assign cfg_bus.mgmt_ena        = cfg[CFG_MGMT_ENA];
    assign cfg_bus.gpio_outenb     = cfg[CFG_OUTENB];
    assign cfg_bus.cfg_valid       = vld;
    assign cfg_bus.cfg_short       = short;

endmodule

// File: tb/tb_gpio_config_shreg.sv
// Directed bench for gpio_config_shreg: two pads chained, loads checked through a scoreboard.
module tb_gpio_config_shreg;
    import gpio_cfg_pkg::*;

    localparam int W = GPIO_CFG_WIDTH;
    localparam logic [W-1:0] DEFAULTS = 10'h2A5;

    typedef struct packed {
        logic [W-1:0] cfg;
        logic         short;
    } exp_t;

    logic serial_clock = 1'b0;
    logic resetn       = 1'b0;
    always #5 serial_clock = ~serial_clock;

    gpio_config_shreg_if #(.WIDTH(W)) up_if ();
    gpio_config_shreg_if #(.WIDTH(W)) dn_if ();

    // Downstream pad shares the control strobes and takes its data from the upstream pad.
    assign dn_if.gpio_defaults   = up_if.gpio_defaults;
    assign dn_if.serial_data_in  = up_if.serial_data_out;
    assign dn_if.serial_shift    = up_if.serial_shift;
    assign dn_if.serial_load     = up_if.serial_load;
    assign dn_if.defaults_reload = up_if.defaults_reload;

    gpio_config_shreg #(.WIDTH(W)) u_up (
        .serial_clock (serial_clock),
        .resetn       (resetn),
        .cfg_bus      (up_if.slave)
    );

    gpio_config_shreg #(.WIDTH(W)) u_dn (
        .serial_clock (serial_clock),
        .resetn       (resetn),
        .cfg_bus      (dn_if.slave)
    );

    int tests  = 0;
    int failed = 0;
    exp_t sb[$];
    logic [W-1:0] shreg_model;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge serial_clock);
        #1;
    endtask

    task automatic shift_bit(input logic b);
        up_if.serial_shift   = 1'b1;
        up_if.serial_data_in = b;
        tick();
        up_if.serial_shift   = 1'b0;
        shreg_model = {shreg_model[W-2:0], b};
    endtask

    task automatic shift_word(input logic [W-1:0] word, input int nbits, input logic [W-1:0] held_cfg);
        for (int i = nbits - 1; i >= 0; i--) begin
            shift_bit(word[i]);
            check("cfg_held_during_shift", 32'(up_if.gpio_config), 32'(held_cfg));
        end
    endtask

    task automatic load_and_score(input logic exp_short);
        exp_t e;
        up_if.serial_load = 1'b1;
        sb.push_back({shreg_model, exp_short});
        tick();
        up_if.serial_load = 1'b0;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("load_cfg", 32'(up_if.gpio_config), 32'(e.cfg));
            check("load_short", 32'(up_if.cfg_short), 32'(e.short));
        end
    endtask

    task automatic reload();
        up_if.defaults_reload = 1'b1;
        tick();
        up_if.defaults_reload = 1'b0;
        shreg_model = DEFAULTS;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_cfg"},    32'(up_if.gpio_config),     32'd0);
        check({tag, "_sdo"},    32'(up_if.serial_data_out), 32'd0);
        check({tag, "_mgmt"},   32'(up_if.mgmt_ena),        32'd0);
        check({tag, "_outenb"}, 32'(up_if.gpio_outenb),     32'd0);
        check({tag, "_valid"},  32'(up_if.cfg_valid),       32'd0);
        check({tag, "_short"},  32'(up_if.cfg_short),       32'd0);
    endtask

    initial begin
        up_if.gpio_defaults   = DEFAULTS;
        up_if.serial_data_in  = 1'b0;
        up_if.serial_shift    = 1'b0;
        up_if.serial_load     = 1'b0;
        up_if.defaults_reload = 1'b0;
        shreg_model           = '0;

        // 1. Reset and power-on capture
        repeat (3) tick();
        check_cleared("reset");
        check("reset_dn_cfg", 32'(dn_if.gpio_config), 32'd0);
        resetn = 1'b1;
        tick();
        shreg_model = DEFAULTS;
        check("init_cfg",    32'(up_if.gpio_config),     32'h2A5);
        check("init_valid",  32'(up_if.cfg_valid),       32'd1);
        check("init_mgmt",   32'(up_if.mgmt_ena),        32'd1);
        check("init_outenb", 32'(up_if.gpio_outenb),     32'd0);
        check("init_sdo",    32'(up_if.serial_data_out), 32'd1);
        check("init_short",  32'(up_if.cfg_short),       32'd0);

        // 2. Full shift then load
        shift_word(10'h1C3, W, DEFAULTS);
        load_and_score(1'b0);
        check("full_load_value", 32'(up_if.gpio_config), 32'h1C3);

        // 3. Short load, sticky through a full load, cleared by reload
        reload();
        check("reload_cfg", 32'(up_if.gpio_config), 32'h2A5);
        shift_word(10'h02D, 6, DEFAULTS);
        load_and_score(1'b1);
        check("short_load_value", 32'(up_if.gpio_config), 32'h16D);
        shift_word(10'h0F0, W, 10'h16D);
        load_and_score(1'b1);
        reload();
        check("reload_clears_short", 32'(up_if.cfg_short), 32'd0);
        check("reload_cfg2",         32'(up_if.gpio_config), 32'h2A5);

        // 4. Simultaneous strobes: reload wins, then load+shift commits the pre-shift word
        up_if.defaults_reload = 1'b1;
        up_if.serial_load     = 1'b1;
        up_if.serial_shift    = 1'b1;
        up_if.serial_data_in  = 1'b1;
        tick();
        up_if.defaults_reload = 1'b0;
        up_if.serial_load     = 1'b0;
        up_if.serial_shift    = 1'b0;
        shreg_model = DEFAULTS;
        check("simul_cfg",   32'(up_if.gpio_config), 32'h2A5);
        check("simul_short", 32'(up_if.cfg_short),   32'd0);
        shift_word(10'h3FF, W, DEFAULTS);
        up_if.serial_shift   = 1'b1;
        up_if.serial_data_in = 1'b0;
        load_and_score(1'b0);
        up_if.serial_shift = 1'b0;
        shreg_model = {shreg_model[W-2:0], 1'b0};
        check("load_shift_cfg", 32'(up_if.gpio_config), 32'h3FF);
        // Counter restarted at one, so committing now is a short load of 10'h3FE.
        load_and_score(1'b1);
        check("load_shift_shreg", 32'(up_if.gpio_config), 32'h3FE);

        // 5. Daisy chain of two pads, 20 bits and one load
        reload();
        shift_word(10'h155, W, DEFAULTS);
        shift_word(10'h2CC, W, DEFAULTS);
        load_and_score(1'b0);
        check("chain_up_cfg",   32'(up_if.gpio_config), 32'h2CC);
        check("chain_dn_cfg",   32'(dn_if.gpio_config), 32'h155);
        check("chain_dn_short", 32'(dn_if.cfg_short),   32'd0);

        // 6. Asynchronous reset in the middle of a shift
        shift_word(10'h003, 2, 10'h2CC);
        load_and_score(1'b1);
        shift_word(10'h00A, 4, shreg_model);
        resetn = 1'b0;
        #2;
        check_cleared("async_reset");
        tick();
        tick();
        resetn = 1'b1;
        tick();
        check("rerun_init_cfg",   32'(up_if.gpio_config), 32'h2A5);
        check("rerun_init_short", 32'(up_if.cfg_short),   32'd0);
        check("rerun_init_valid", 32'(up_if.cfg_valid),   32'd1);
        check("rerun_dn_cfg",     32'(dn_if.gpio_config), 32'h2A5);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/gpio_config_shreg.md
Name: gpio_config_shreg

Overview:
Per-pad configuration register that consumes the static 10-bit `gpio_defaults` word from the defaults tie-cell block. After reset it captures that word as the pad's power-on configuration. It then lets the housekeeping serial chain shift in and commit a new configuration. It is daisy-chained pad-to-pad through `serial_data_in` / `serial_data_out`. It drives the pad configuration bus.

Parameters:
- WIDTH, 10, configuration word width; must equal the width of `gpio_defaults`.
- CNT_W, 4, bit-counter width; derived as clog2(WIDTH+1); not overridden.

Ports:
- serial_clock  input  1  sole clock; all state updates on its rising edge.
- resetn  input  1  reset, asynchronous, active-low. Deassertion is synchronised upstream.
- gpio_defaults  input  WIDTH  static power-on configuration from the defaults tie-cell block.
- serial_data_in  input  1  serial config bit from the previous pad in the chain.
- serial_shift  input  1  shift enable, sampled each clock.
- serial_load  input  1  one-cycle strobe: commit shift register to config.
- defaults_reload  input  1  one-cycle strobe: restore `gpio_defaults` into shift and config.
- serial_data_out  output  1  MSB of the shift register, to the next pad.
- gpio_config  output  WIDTH  committed configuration.
- Field map of `gpio_config`:
  - [0] mgmt_ena, [1] outenb, [2] holdover, [3] inp_dis
  - [4] pullup, [5] pulldown, [6] schmitt_sel, [7] slew_sel, [9:8] drive_sel
- mgmt_ena  output  1  copy of gpio_config[0].
- gpio_outenb  output  1  copy of gpio_config[1].
- cfg_valid  output  1  high once the power-on defaults have been captured.
- cfg_short  output  1  sticky flag: a load was committed with fewer than WIDTH bits shifted since the previous load or reload.

Behaviour:
- While resetn is low, the following are all 0:
  - shift register, gpio_config, serial_data_out, mgmt_ena, gpio_outenb
  - cfg_valid, cfg_short
  - bit counter
  - FSM is held in INIT.
- FSM has two states, INIT and RUN.
- INIT: on the first rising edge after resetn deasserts:
  - shift register <= gpio_defaults; gpio_config <= gpio_defaults
  - cfg_valid <= 1; counter <= 0; FSM -> RUN
  - serial_shift, serial_load and defaults_reload are ignored in INIT.
  - Latency from resetn rising to valid config: 1 clock.
- RUN, evaluated each clock in priority order:
  1. defaults_reload=1: shift register and gpio_config <= gpio_defaults; counter <= 0; cfg_short <= 0. Any simultaneous shift or load is dropped.
  2. Else if serial_load=1: gpio_config <= shift register (its pre-edge value); counter <= 0; cfg_short <= cfg_short | (counter < WIDTH).
     - If serial_shift=1 in the same cycle, the shift also occurs: gpio_config takes the pre-shift contents and counter <= 1.
  3. Else if serial_shift=1: shift register <= {shift[WIDTH-2:0], serial_data_in}, MSB-first. Counter increments, saturating at WIDTH.
- serial_data_out = shift[WIDTH-1], directly from the register with no combinational path from inputs. It changes only on clock edges, so the chain carries one bit per clock per pad.
- gpio_config changes only in INIT, on a load, or on a reload. Shifting never disturbs the committed configuration.
- mgmt_ena and gpio_outenb are pure wires from gpio_config, with zero latency relative to it.
- cfg_short is cleared only by reset or defaults_reload.
- If resetn asserts mid-shift, all state clears immediately, asynchronously. The next deassertion re-runs INIT.
- Counter saturation: any number of shifts above WIDTH leaves counter=WIDTH. A load then does not set cfg_short.

Decomposition:
- Shared package gpio_cfg_pkg holds:
  - GPIO_CFG_WIDTH = 10
  - field bit-index constants (CFG_MGMT_ENA=0 … CFG_DRIVE_SEL_LSB=8)
  - FSM state enum {INIT, RUN}
- No sub-module. The shift register, counter and FSM fit in one block.

Test Plan:
1. Reset/INIT: gpio_defaults=10'h2A5, resetn low 3 cycles then high.
   - During reset, all outputs are 0.
   - One clock after release: gpio_config=10'h2A5, cfg_valid=1, mgmt_ena=1, gpio_outenb=0, serial_data_out=1.
2. Shift and load: shift 10 bits of 10'h1C3, MSB first, then pulse serial_load.
   - gpio_config=10'h1C3 after the load edge; cfg_short=0.
   - gpio_config stays 10'h2A5 throughout the shifting.
3. Short load: after reload, shift 6 bits, then serial_load.
   - gpio_config = shift register contents; cfg_short=1.
   - cfg_short stays 1 through a subsequent full 10-bit load.
   - It clears on defaults_reload.
4. Simultaneous events: serial_load, serial_shift and defaults_reload asserted together → gpio_config=gpio_defaults, counter=0.
   - Next cycle, serial_load+serial_shift with shift=10'h3FF and serial_data_in=0 → gpio_config=10'h3FF, shift=10'h3FE.
5. Daisy chain: two instances chained, 20 bits shifted, one load.
   - Downstream instance holds the first 10 bits sent; upstream holds the last 10.
6. Mid-operation reset: assert resetn after 4 of 10 shifts.
   - Outputs clear immediately, without waiting for a clock edge.
   - After release, config = gpio_defaults and cfg_short=0.
